seg_scan_decoder: RTL

Receive-side counterpart of the parking-meter display driver. The block samples the multiplexed 4-digit 7-segment bus (active-low segments, active-low anodes a1..a4) and reconstructs the displayed BCD digits and the 14-bit value. It also reports blanking (flash-off phases) and protocol errors. It sits on the board loopback / self-check path and is a DUT companion in system benches.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg_scan_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: active-low digit
// patterns, scan-decoder FSM encoding and decimal digit weights.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2,
    GOT3 = 2'd3
  } state_e;

  localparam logic [13:0] W_THOUSANDS = 14'd1000;
  localparam logic [13:0] W_HUNDREDS  = 14'd100;
  localparam logic [13:0] W_TENS      = 14'd10;

  function automatic logic [13:0] bcd_to_value(input logic [3:0] d1,
                                               input logic [3:0] d2,
                                               input logic [3:0] d3,
                                               input logic [3:0] d4);
    return 14'(d1) * W_THOUSANDS + 14'(d2) * W_HUNDREDS
         + 14'(d3) * W_TENS + 14'(d4);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Active-low 7-segment pattern to BCD digit; anything outside the ten
// digit glyphs is flagged illegal.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       legal_o
);

  always_comb begin
    bcd_o   = '0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 4-digit active-low 7-segment bus and rebuilds the
// displayed digits/value, with blanking detection and protocol error pulses.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  led_seg,
  input  logic        a1,
  input  logic        a2,
  input  logic        a3,
  input  logic        a4,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic [3:0]  dig4,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        blank,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [7:0] BLANK_MAX = 8'(BLANK_CYCLES);

  logic [6:0]  seg_q;
  logic [3:0]  an_q;
  logic        smp_vld_q;
  state_e      state_q, state_d;
  logic [3:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [3:0]  dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;
  logic [13:0] value_q, value_d;
  logic        fv_q, fv_d, se_q, se_d, ae_q, ae_d, blank_q, blank_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        slot_act, slot_blank, an_err;
  logic [1:0]  slot_idx;
  logic [3:0]  dig_dec;
  logic        dig_legal;

  seg7_to_bcd u_dec (
    .seg_i   (seg_q),
    .bcd_o   (dig_dec),
    .legal_o (dig_legal)
  );

  // The input registers reset to 0 (all anodes "on"); smp_vld_q keeps that
  // reset image from being classified as an anode error on the first edge.
  always_comb begin
    slot_act   = 1'b0;
    slot_blank = 1'b0;
    an_err     = 1'b0;
    slot_idx   = 2'd0;
    if (smp_vld_q) begin
      case (an_q)
        4'b0111: begin slot_act = 1'b1; slot_idx = 2'd0; end
        4'b1011: begin slot_act = 1'b1; slot_idx = 2'd1; end
        4'b1101: begin slot_act = 1'b1; slot_idx = 2'd2; end
        4'b1110: begin slot_act = 1'b1; slot_idx = 2'd3; end
        4'b1111: slot_blank = 1'b1;
        default: an_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    dig1_d  = dig1_q;
    dig2_d  = dig2_q;
    dig3_d  = dig3_q;
    dig4_d  = dig4_q;
    value_d = value_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    ae_d    = 1'b0;
    cnt_d   = cnt_q;
    blank_d = blank_q;

    if (an_err) begin
      ae_d    = 1'b1;
      state_d = IDLE;
    end else if (slot_act && !dig_legal) begin
      se_d    = 1'b1;
      state_d = IDLE;
    end else if (slot_act) begin
      case (slot_idx)
        2'd0: begin
          state_d = GOT1;
          d1_d    = dig_dec;
        end
        2'd1: begin
          if (state_q inside {GOT1, GOT2}) begin
            state_d = GOT2;
            d2_d    = dig_dec;
          end else begin
            state_d = IDLE;
          end
        end
        2'd2: begin
          if (state_q inside {GOT2, GOT3}) begin
            state_d = GOT3;
            d3_d    = dig_dec;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          if (state_q == GOT3) begin
            fv_d    = 1'b1;
            dig1_d  = d1_q;
            dig2_d  = d2_q;
            dig3_d  = d3_q;
            dig4_d  = dig_dec;
            value_d = bcd_to_value(d1_q, d2_q, d3_q, dig_dec);
          end
        end
      endcase
    end else if (slot_blank) begin
      state_d = IDLE;
    end

    if (slot_blank) begin
      if (cnt_q != BLANK_MAX) cnt_d = cnt_q + 8'd1;
      if (cnt_q == BLANK_MAX - 8'd1) blank_d = 1'b1;
    end else if (smp_vld_q) begin
      cnt_d = '0;
    end
    if (fv_d) blank_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= '0;
      an_q      <= '0;
      smp_vld_q <= 1'b0;
      state_q   <= IDLE;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      dig1_q    <= '0;
      dig2_q    <= '0;
      dig3_q    <= '0;
      dig4_q    <= '0;
      value_q   <= '0;
      fv_q      <= 1'b0;
      se_q      <= 1'b0;
      ae_q      <= 1'b0;
      blank_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      seg_q     <= led_seg;
      an_q      <= {a1, a2, a3, a4};
      smp_vld_q <= 1'b1;
      state_q   <= state_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      dig1_q    <= dig1_d;
      dig2_q    <= dig2_d;
      dig3_q    <= dig3_d;
      dig4_q    <= dig4_d;
      value_q   <= value_d;
      fv_q      <= fv_d;
      se_q      <= se_d;
      ae_q      <= ae_d;
      blank_q   <= blank_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dig1        = dig1_q;
  assign dig2        = dig2_q;
  assign dig3        = dig3_q;
  assign dig4        = dig4_q;
  assign value       = value_q;
  assign frame_valid = fv_q;
  assign blank       = blank_q;
  assign seg_err     = se_q;
  assign anode_err   = ae_q;

endmodule
